capture_sequencer: RTL and testbench

Parametrised trigger and record sequencer for the FDA acquisition path. It generalises the top-level trigger, arm and record glue into one state machine with these additions: multiple maskable trigger sources, a programmable post-trigger sample count, FIFO-drain tracking, holdoff, and optional automatic re-arm. It sits between Main_FSM/TriggerControl and DataStorage. It drives the FIFO write strobe and the comparator reset request.

---
 rtl/capture_sequencer.sv | 126 ++++++++++++
 tb/tb_capture_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/capture_sequencer.sv
// Trigger/arm/record sequencer: edge-detects masked trigger sources, writes N samples, waits for drain and holdoff.
// Registered state; record is the CAPTURE state gated by fifo_full so no write is ever issued into a full FIFO.
module capture_sequencer #(
  parameter int NUM_TRIG = 4,
  parameter int CNT_W    = 16,
  parameter int HOLD_W   = 8
) (
  input  logic                          clk,
  input  logic                          Reset_n,
  input  logic                          arm,
  input  logic                          disarm,
  input  logic                          force_trig,
  input  logic [NUM_TRIG-1:0]           trig_in,
  input  logic [NUM_TRIG-1:0]           trig_mask,
  input  logic                          auto_rearm,
  input  logic [CNT_W-1:0]              post_count,
  input  logic [HOLD_W-1:0]             holdoff,
  input  logic                          clock_lock,
  input  logic                          fifo_full,
  input  logic                          fifo_empty,
  output logic                          record,
  output logic                          trig_reset,
  output logic                          triggered,
  output logic [$clog2(NUM_TRIG+1)-1:0] trig_src,
  output logic [2:0]                    state,
  output logic                          overflow,
  output logic                          lock_lost
);

  localparam int SRC_W = $clog2(NUM_TRIG + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ARMED   = 3'd1;
  localparam logic [2:0] S_CAPTURE = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_HOLDOFF = 3'd4;

  logic [NUM_TRIG-1:0] prev;
  logic [NUM_TRIG-1:0] rise;
  logic                any_rise;
  logic [SRC_W-1:0]    rise_src;
  logic [CNT_W-1:0]    cnt;
  logic [HOLD_W-1:0]   hcnt;

  // Lowest-index rising source wins; force_trig only shows up when no source rose.
  always_comb begin
    rise     = trig_in & ~prev & trig_mask;
    any_rise = |rise;
    rise_src = SRC_W'(NUM_TRIG);
    for (int i = NUM_TRIG - 1; i >= 0; i--) begin
      if (rise[i]) rise_src = SRC_W'(i);
    end
  end

  assign record = (state == S_CAPTURE) && !fifo_full;

  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      state      <= S_IDLE;
      prev       <= '0;
      cnt        <= '0;
      hcnt       <= '0;
      trig_reset <= 1'b0;
      triggered  <= 1'b0;
      trig_src   <= '0;
      overflow   <= 1'b0;
      lock_lost  <= 1'b0;
    end else begin
      prev       <= trig_in;
      trig_reset <= 1'b0;
      if (state != S_IDLE && !clock_lock) begin
        state     <= S_IDLE;
        triggered <= 1'b0;
        lock_lost <= 1'b1;
      end else if (disarm) begin
        state     <= S_IDLE;
        triggered <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (arm && clock_lock) begin
              state     <= S_ARMED;
              overflow  <= 1'b0;
              lock_lost <= 1'b0;
            end
          end
          S_ARMED: begin
            if (force_trig || any_rise) begin
              state     <= S_CAPTURE;
              trig_src  <= rise_src;
              triggered <= 1'b1;
              cnt       <= (post_count == '0) ? CNT_W'(1) : post_count;
            end
          end
          S_CAPTURE: begin
            if (fifo_full) begin
              overflow <= 1'b1;
              state    <= S_DRAIN;
            end else begin
              cnt <= cnt - 1'b1;
              if (cnt <= CNT_W'(1)) state <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            if (fifo_empty) begin
              state      <= S_HOLDOFF;
              hcnt       <= holdoff;
              trig_reset <= 1'b1;
            end
          end
          S_HOLDOFF: begin
            // A load of 0 or 1 both yield a single HOLDOFF cycle.
            if (hcnt <= HOLD_W'(1)) begin
              state     <= auto_rearm ? S_ARMED : S_IDLE;
              triggered <= 1'b0;
            end else begin
              hcnt <= hcnt - 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_capture_sequencer.sv
// Cycle-view vector bench for capture_sequencer: each vector holds inputs for one cycle and the outputs expected
// during that cycle; record bursts are checked against lengths queued when the triggering stimulus is applied.
module tb_capture_sequencer;

  logic        clk = 1'b0;
  logic        Reset_n;
  logic        arm, disarm, force_trig, auto_rearm, clock_lock, fifo_full, fifo_empty;
  logic [3:0]  trig_in, trig_mask;
  logic [15:0] post_count;
  logic [7:0]  holdoff;
  logic        record, trig_reset, triggered, overflow, lock_lost;
  logic [2:0]  trig_src;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;
  int vec_no = 0;
  int sb_q[$];
  int run    = 0;
  int bursts = 0;

  typedef struct {
    int rn, arm, dis, frc, mask, trig, lock, full, empty, push;
    int st, rec, trg, trst, src, ovf, ll;
  } vec_t;

  capture_sequencer #(.NUM_TRIG(4), .CNT_W(16), .HOLD_W(8)) dut (
    .clk(clk), .Reset_n(Reset_n), .arm(arm), .disarm(disarm), .force_trig(force_trig),
    .trig_in(trig_in), .trig_mask(trig_mask), .auto_rearm(auto_rearm), .post_count(post_count),
    .holdoff(holdoff), .clock_lock(clock_lock), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .record(record), .trig_reset(trig_reset), .triggered(triggered), .trig_src(trig_src),
    .state(state), .overflow(overflow), .lock_lost(lock_lost)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input int rn, arm_i, dis, frc, mask, trig, lock, full, empty, push,
                              input int st, rec, trg, trst, src, ovf, ll);
    vec_t v;
    v.rn = rn; v.arm = arm_i; v.dis = dis; v.frc = frc; v.mask = mask; v.trig = trig;
    v.lock = lock; v.full = full; v.empty = empty; v.push = push;
    v.st = st; v.rec = rec; v.trg = trg; v.trst = trst; v.src = src; v.ovf = ovf; v.ll = ll;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input int exp);
    checks++;
    if (act !== 32'(exp)) begin
      errors++;
      $display("FAIL %s vec %0d: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  // Called just after a rising edge: drive, check mid-cycle, advance to the next edge.
  task automatic apply(input vec_t v);
    Reset_n    = v.rn[0];
    arm        = v.arm[0];
    disarm     = v.dis[0];
    force_trig = v.frc[0];
    trig_mask  = v.mask[3:0];
    trig_in    = v.trig[3:0];
    clock_lock = v.lock[0];
    fifo_full  = v.full[0];
    fifo_empty = v.empty[0];
    if (v.push != 0) sb_q.push_back(v.push);
    @(negedge clk);
    chk("state",      vec_no, 32'(state),      v.st);
    chk("record",     vec_no, 32'(record),     v.rec);
    chk("triggered",  vec_no, 32'(triggered),  v.trg);
    chk("trig_reset", vec_no, 32'(trig_reset), v.trst);
    chk("trig_src",   vec_no, 32'(trig_src),   v.src);
    chk("overflow",   vec_no, 32'(overflow),   v.ovf);
    chk("lock_lost",  vec_no, 32'(lock_lost),  v.ll);
    vec_no++;
    @(posedge clk);
    #1;
  endtask

  // Record-burst scoreboard.
  always @(negedge clk) begin
    if (record === 1'b1) begin
      run++;
    end else if (run != 0) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL burst_unexpected: got %0d records expected none", run);
      end else begin
        chk("burst_len", bursts, 32'(run), sb_q.pop_front());
      end
      bursts++;
      run = 0;
    end
  end

  initial begin
    vec_t tbl[21];
    // rn arm dis frc mask trig lk fl em push | st rec trg trst src ovf ll
    tbl[0]  = mk(1,1,0,0,'hF,'h0,1,0,0,0, 0,0,0,0,0,0,0);
    tbl[1]  = mk(1,0,0,0,'hF,'h0,1,0,0,0, 1,0,0,0,0,0,0);
    tbl[2]  = mk(1,0,0,0,'hF,'h4,1,0,0,5, 1,0,0,0,0,0,0);
    tbl[3]  = mk(1,0,0,0,'hF,'h4,1,0,0,0, 2,1,1,0,2,0,0);
    tbl[4]  = mk(1,0,0,0,'hF,'h4,1,0,0,0, 2,1,1,0,2,0,0);
    tbl[5]  = mk(1,0,0,0,'hF,'h4,1,0,0,0, 2,1,1,0,2,0,0);
    tbl[6]  = mk(1,0,0,0,'hF,'h4,1,0,0,0, 2,1,1,0,2,0,0);
    tbl[7]  = mk(1,0,0,0,'hF,'h4,1,0,0,0, 2,1,1,0,2,0,0);
    tbl[8]  = mk(1,0,0,0,'hF,'h4,1,0,0,0, 3,0,1,0,2,0,0);
    tbl[9]  = mk(1,0,0,0,'hF,'h4,1,0,1,0, 3,0,1,0,2,0,0);
    tbl[10] = mk(1,0,0,0,'hF,'h4,1,0,1,0, 4,0,1,1,2,0,0);
    tbl[11] = mk(1,0,0,0,'hF,'h4,1,0,1,0, 4,0,1,0,2,0,0);
    tbl[12] = mk(1,0,0,0,'hF,'h4,1,0,1,0, 4,0,1,0,2,0,0);
    tbl[13] = mk(1,0,0,0,'hF,'h4,1,0,0,0, 1,0,0,0,2,0,0);
    tbl[14] = mk(1,0,0,0,'hF,'h0,1,0,0,0, 1,0,0,0,2,0,0);
    tbl[15] = mk(1,0,0,1,'hF,'hA,1,0,0,1, 1,0,0,0,2,0,0);
    tbl[16] = mk(1,0,1,0,'hF,'hA,1,0,0,0, 2,1,1,0,1,0,0);
    tbl[17] = mk(1,1,0,0,'h0,'h0,1,0,0,0, 0,0,0,0,1,0,0);
    tbl[18] = mk(1,0,0,1,'h0,'hF,1,0,0,1, 1,0,0,0,1,0,0);
    tbl[19] = mk(1,0,1,0,'h0,'h0,1,0,0,0, 2,1,1,0,4,0,0);
    tbl[20] = mk(1,0,0,0,'hF,'h0,1,0,0,0, 0,0,0,0,4,0,0);

    Reset_n = 1'b0; arm = 1'b0; disarm = 1'b0; force_trig = 1'b0; trig_in = '0; trig_mask = 4'hF;
    clock_lock = 1'b1; fifo_full = 1'b0; fifo_empty = 1'b0;
    post_count = 16'd5; holdoff = 8'd3; auto_rearm = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Basic capture, auto re-arm with holdoff 3, held level, priority, masked force.
    for (int i = 0; i < 21; i++) apply(tbl[i]);

    // FIFO full on the 10th record cycle, disarm in DRAIN, overflow cleared by arm.
    post_count = 16'd100; holdoff = 8'd0; auto_rearm = 1'b0;
    apply(mk(1,1,0,0,'hF,'h0,1,0,0,0, 0,0,0,0,4,0,0));
    apply(mk(1,0,0,0,'hF,'h1,1,0,0,9, 1,0,0,0,4,0,0));
    for (int k = 0; k < 9; k++) apply(mk(1,0,0,0,'hF,'h1,1,0,0,0, 2,1,1,0,0,0,0));
    apply(mk(1,0,0,0,'hF,'h1,1,1,0,0, 2,0,1,0,0,0,0));
    apply(mk(1,0,0,0,'hF,'h1,1,0,0,0, 3,0,1,0,0,1,0));
    apply(mk(1,0,1,0,'hF,'h1,1,0,0,0, 3,0,1,0,0,1,0));
    apply(mk(1,0,0,0,'hF,'h1,1,0,0,0, 0,0,0,0,0,1,0));
    apply(mk(1,1,0,0,'hF,'h1,1,0,0,0, 0,0,0,0,0,1,0));

    // Clock loss mid-capture, then arm without clock is ignored.
    apply(mk(1,0,0,0,'hF,'h2,1,0,0,2, 1,0,0,0,0,0,0));
    apply(mk(1,0,0,0,'hF,'h2,1,0,0,0, 2,1,1,0,1,0,0));
    apply(mk(1,0,0,0,'hF,'h2,0,0,0,0, 2,1,1,0,1,0,0));
    apply(mk(1,1,0,0,'hF,'h2,0,0,0,0, 0,0,0,0,1,0,1));
    apply(mk(1,0,0,0,'hF,'h2,0,0,0,0, 0,0,0,0,1,0,1));
    apply(mk(1,1,0,0,'hF,'h2,1,0,0,0, 0,0,0,0,1,0,1));

    // Reset during capture; a level held across reset must toggle before it triggers.
    apply(mk(1,0,0,0,'hF,'h4,1,0,0,1, 1,0,0,0,1,0,0));
    apply(mk(0,0,0,0,'hF,'h4,1,0,0,0, 2,1,1,0,2,0,0));
    apply(mk(1,0,0,0,'hF,'h4,1,0,0,0, 0,0,0,0,0,0,0));
    apply(mk(1,1,0,0,'hF,'h4,1,0,0,0, 0,0,0,0,0,0,0));
    apply(mk(1,0,0,0,'hF,'h4,1,0,0,0, 1,0,0,0,0,0,0));
    apply(mk(1,0,0,0,'hF,'h0,1,0,0,0, 1,0,0,0,0,0,0));
    apply(mk(1,0,0,0,'hF,'h4,1,0,0,1, 1,0,0,0,0,0,0));
    apply(mk(1,0,1,0,'hF,'h4,1,0,0,0, 2,1,1,0,2,0,0));
    apply(mk(1,0,0,0,'hF,'h0,1,0,0,0, 0,0,0,0,2,0,0));

    // post_count 0 records once; holdoff 0 is a single HOLDOFF cycle back to IDLE.
    post_count = 16'd0;
    apply(mk(1,1,0,0,'hF,'h0,1,0,0,0, 0,0,0,0,2,0,0));
    apply(mk(1,0,0,0,'hF,'h8,1,0,0,1, 1,0,0,0,2,0,0));
    apply(mk(1,0,0,0,'hF,'h8,1,0,0,0, 2,1,1,0,3,0,0));
    apply(mk(1,0,0,0,'hF,'h8,1,0,1,0, 3,0,1,0,3,0,0));
    apply(mk(1,0,0,0,'hF,'h8,1,0,1,0, 4,0,1,1,3,0,0));
    apply(mk(1,0,0,0,'hF,'h8,1,0,1,0, 0,0,0,0,3,0,0));

    repeat (3) @(posedge clk);
    chk("bursts_pending", 0, 32'(sb_q.size()), 0);
    chk("burst_count", 0, 32'(bursts), 8);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
